// File: rtl/sif_xa_arbiter_if.sv
// Bundle between the NREQ requesters, the round-robin arbiter and the SIF
// xa host port.
//   slave  : the arbiter's view. It takes requests and xa_data_rd, and it
//            drives the grants, the read returns and the xa strobes/bus.
//   master : the view of the requester/SIF side, with every direction reversed.
// Signals:
//   req, req_wr, req_addr, req_wdata : per-requester request level, op
//       (1 = write) and packed address/data. Requester i sits at
//       [i*AW +: AW] and [i*DW +: DW].
//   gnt, rd_valid, rd_data, busy : one-hot acceptance, one-hot read-return
//       pulse, the shared read data, and the busy flag.
//   xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, xa_data_rd : the SIF xa port.
interface sif_xa_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;
    logic               busy;
    logic [AW-1:0]      xa_addr;
    logic [DW-1:0]      xa_data_wr;
    logic               xa_wr_s;
    logic               xa_rd_s;
    logic [DW-1:0]      xa_data_rd;

    modport slave (
        input  req, req_wr, req_addr, req_wdata, xa_data_rd,
        output gnt, rd_valid, rd_data, busy,
               xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
    );

    modport master (
        output req, req_wr, req_addr, req_wdata, xa_data_rd,
        input  gnt, rd_valid, rd_data, busy,
               xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
    );
endinterface

// File: rtl/sif_xa_arbiter.sv
// Round-robin arbiter that shares the SIF xa host port among NREQ requesters.
// It accepts one request at a time and issues a one-cycle write or read
// strobe. For a read, it captures xa_data_rd in the next cycle and returns
// it to the requester that issued the read.
// Ports:
//   clk : clock; all state updates on the rising edge.
//   rst : synchronous, active-high reset.
//   bus : sif_xa_arbiter_if.slave, which carries the request/grant side and
//         the xa side.
//
// state  | meaning
// IDLE   | no transaction in flight; the round-robin winner is granted combinationally
// ISSUE  | one xa strobe is high for this cycle
// RDWAIT | the SIF presents xa_data_rd; capture it and pulse rd_valid
module sif_xa_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    sif_xa_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic            op_wr_q, op_wr_d;
    logic [AW-1:0]   xa_addr_q, xa_addr_d;
    logic [DW-1:0]   xa_data_q, xa_data_d;
    logic            wr_s_q, wr_s_d;
    logic            rd_s_q, rd_s_d;
    logic [NREQ-1:0] rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;

    logic            any_req;
    logic [IW-1:0]   pick;
    logic [NREQ-1:0] gnt_w;

    // The scan runs from the farthest offset down to the nearest, so the
    // nearest requester above ptr is written last and wins. The previous
    // winner sits at offset NREQ, which makes it lowest priority.
    always_comb begin : rr_pick
        int idx;
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req[idx]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

    always_comb begin : gnt_gen
        gnt_w = '0;
        if (state_q == IDLE && !rst && any_req) gnt_w[pick] = 1'b1;
    end

    always_comb begin : next_state
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        op_wr_d    = op_wr_q;
        xa_addr_d  = xa_addr_q;
        xa_data_d  = xa_data_q;
        wr_s_d     = 1'b0;
        rd_s_d     = 1'b0;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    xa_addr_d = bus.req_addr[int'(pick)*AW +: AW];
                    xa_data_d = bus.req_wdata[int'(pick)*DW +: DW];
                    op_wr_d   = bus.req_wr[pick];
                    wr_s_d    = bus.req_wr[pick];
                    rd_s_d    = !bus.req_wr[pick];
                    win_d     = pick;
                    ptr_d     = pick;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = op_wr_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                rd_data_d         = bus.xa_data_rd;
                rd_valid_d[win_q] = 1'b1;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NREQ - 1);
            win_q      <= '0;
            op_wr_q    <= 1'b0;
            xa_addr_q  <= '0;
            xa_data_q  <= '0;
            wr_s_q     <= 1'b0;
            rd_s_q     <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            op_wr_q    <= op_wr_d;
            xa_addr_q  <= xa_addr_d;
            xa_data_q  <= xa_data_d;
            wr_s_q     <= wr_s_d;
            rd_s_q     <= rd_s_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.gnt        = gnt_w;
    assign bus.busy       = (state_q != IDLE);
    assign bus.xa_addr    = xa_addr_q;
    assign bus.xa_data_wr = xa_data_q;
    assign bus.xa_wr_s    = wr_s_q;
    assign bus.xa_rd_s    = rd_s_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Directed bench for sif_xa_arbiter with NREQ=4 and AW=DW=16.
// A table of per-cycle vectors applies the inputs after each rising edge and
// compares all outputs a little later in the same cycle. Hand-written
// sequences then cover fairness and a reset that lands in RDWAIT.
// A small SIF model returns read data in the cycle after xa_rd_s.
module tb_sif_xa_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    sif_xa_arbiter_if #(.NREQ(4), .AW(16), .DW(16)) bus ();

    sif_xa_arbiter #(.NREQ(4), .AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] sif_model(input logic [15:0] a);
        return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // The read data is valid only in the cycle after the strobe. In every
    // other cycle the model returns a marker value.
    always @(posedge clk) bus.xa_data_rd <= bus.xa_rd_s ? sif_model(bus.xa_addr) : 16'hDEAD;

    always @(negedge clk) begin
        if (bus.xa_wr_s && bus.xa_rd_s) begin
            n_miss++;
            $display("FAIL strobe_excl: wr_s=%b rd_s=%b, required not both", bus.xa_wr_s, bus.xa_rd_s);
        end
    end

    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic [3:0]  wr;
        logic [3:0]  g;
        logic        b;
        logic        ws;
        logic        rs;
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  rv;
        logic [15:0] rdd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic r, input logic [3:0] rq, input logic [3:0] wr,
                                 input logic [3:0] g, input logic b, input logic ws, input logic rs,
                                 input logic [15:0] a, input logic [15:0] d,
                                 input logic [3:0] rv, input logic [15:0] rdd);
        vec_t v;
        v.r = r; v.rq = rq; v.wr = wr; v.g = g; v.b = b; v.ws = ws; v.rs = rs;
        v.a = a; v.d = d; v.rv = rv; v.rdd = rdd;
        return v;
    endfunction

    function automatic logic [58:0] outs();
        return {bus.gnt, bus.busy, bus.xa_wr_s, bus.xa_rd_s, bus.xa_addr,
                bus.xa_data_wr, bus.rd_valid, bus.rd_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] wr);
        rst        = r;
        bus.req    = rq;
        bus.req_wr = wr;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_wr    = '0;
        bus.req_addr  = {16'h0030, 16'h0010, 16'h0020, 16'h0040};
        bus.req_wdata = {16'h3333, 16'hBEEF, 16'h1111, 16'h0F0F};

        // single write from requester 2
        tbl.push_back(mkv(1, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 16'h0000, 16'h0000, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0100, 4'b0100, 4'b0100, 0, 0, 0, 16'h0000, 16'h0000, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 16'h0010, 16'hBEEF, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0010, 16'hBEEF, 4'b0000, 16'h0000));
        // single read from requester 1
        tbl.push_back(mkv(0, 4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 16'h0010, 16'hBEEF, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0020, 16'h1111, 4'b0010, 16'h1234));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h1234));
        // round robin with all four writing, starting from reset
        tbl.push_back(mkv(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h1234));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0001, 0, 0, 0, 16'h0000, 16'h0000, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0000, 1, 1, 0, 16'h0040, 16'h0F0F, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0010, 0, 0, 0, 16'h0040, 16'h0F0F, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0000, 1, 1, 0, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0100, 0, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0000, 1, 1, 0, 16'h0010, 16'hBEEF, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b1000, 0, 0, 0, 16'h0010, 16'hBEEF, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0000, 1, 1, 0, 16'h0030, 16'h3333, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0001, 0, 0, 0, 16'h0030, 16'h3333, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0000, 1, 1, 0, 16'h0040, 16'h0F0F, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b1111, 4'b1111, 4'b0010, 0, 0, 0, 16'h0040, 16'h0F0F, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        // mixed traffic: requester 0 writes, then requester 1 reads, queued together
        tbl.push_back(mkv(0, 4'b0011, 4'b0001, 4'b0001, 0, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0, 16'h0040, 16'h0F0F, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 16'h0040, 16'h0F0F, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h0000));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0020, 16'h1111, 4'b0010, 16'h1234));
        tbl.push_back(mkv(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0020, 16'h1111, 4'b0000, 16'h1234));

        step();
        step();

        foreach (tbl[i]) begin
            step();
            drive(tbl[i].r, tbl[i].rq, tbl[i].wr);
            #1;
            chk($sformatf("vec%0d", i), {5'b0, outs()},
                {5'b0, tbl[i].g, tbl[i].b, tbl[i].ws, tbl[i].rs, tbl[i].a, tbl[i].d, tbl[i].rv, tbl[i].rdd});
        end

        // fairness: requester 0 holds its request; requester 3 asks once
        step(); drive(1, 4'b0000, 4'b0000);
        step(); drive(0, 4'b0001, 4'b0001); #1 chk("fair_g0", bus.gnt, 4'b0001);
        step(); drive(0, 4'b1001, 4'b1001); #1 chk("fair_busy_nognt", bus.gnt, 4'b0000);
        step(); #1 chk("fair_g3", bus.gnt, 4'b1000);
        step(); drive(0, 4'b0001, 4'b0001); #1 chk("fair_addr3", bus.xa_addr, 16'h0030);
        step(); #1 chk("fair_g0_again", bus.gnt, 4'b0001);
        step(); drive(0, 4'b0000, 4'b0000);
        step();

        // reset during RDWAIT of a read from requester 0
        step(); drive(1, 4'b0000, 4'b0000);
        step(); drive(0, 4'b0010, 4'b0000); #1 chk("rst_pre_g1", bus.gnt, 4'b0010);
        step(); drive(0, 4'b0000, 4'b0000);
        step();
        step(); #1 chk("rst_pre_rv", {bus.rd_valid, bus.rd_data}, {4'b0010, 16'h1234});
        drive(0, 4'b0001, 4'b0000); #1 chk("rst_g0", bus.gnt, 4'b0001);
        step(); drive(0, 4'b0000, 4'b0000); #1 chk("rst_rd_s", bus.xa_rd_s, 1'b1);
        step(); drive(1, 4'b0000, 4'b0000); #1 chk("rst_rdwait_busy", bus.busy, 1'b1);
        step(); drive(0, 4'b0000, 4'b0000); #1 chk("rst_all_zero", {5'b0, outs()}, 64'h0);
        step(); #1 chk("rst_no_rv", bus.rd_valid, 4'b0000);
        drive(0, 4'b1011, 4'b1011); #1 chk("rst_g0_first", bus.gnt, 4'b0001);
        step(); drive(0, 4'b0000, 4'b0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
